// File: rtl/pipe_stage.sv
// pipe_stage: pipeline stage register with valid/ready handshake, optional two-entry skid buffer, bubble and flush
module pipe_stage #(
  parameter int CTRL_W = 64,
  parameter int DATA_W = 384,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d, in_ctrl_m;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              acc, con;
  assign out_valid = state_q != EMPTY;
  assign in_ready  = !rst && ((SKID != 0) ? (state_q != FULL) : (!out_valid || out_ready));
  assign acc       = in_valid && in_ready;
  assign con       = out_valid && out_ready;
  assign in_ctrl_m = clr ? '0 : in_ctrl;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else if (state_q == EMPTY) begin
      if (acc) begin
        state_d     = BUSY;
        main_ctrl_d = in_ctrl_m;
        main_data_d = in_data;
      end
    end else if (state_q == BUSY) begin
      if (acc && con) begin
        main_ctrl_d = in_ctrl_m;
        main_data_d = in_data;
      end else if (acc && SKID != 0) begin
        state_d     = FULL;
        skid_ctrl_d = in_ctrl_m;
        skid_data_d = in_data;
      end else if (con) begin
        state_d = EMPTY;
      end
    end else if (con) begin
      state_d     = BUSY;
      main_ctrl_d = skid_ctrl_q;
      main_data_d = skid_data_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: table-driven check of pipe_stage in skid mode plus directed sequence for single-register mode
module tb_pipe_stage;
  logic        clk = 0;
  logic        rst, in_valid, in_ready, clr, flush, out_valid, out_ready;
  logic [15:0] in_ctrl, in_data, out_ctrl, out_data;
  logic [1:0]  occupancy;
  logic        z_rst, z_in_valid, z_in_ready, z_clr, z_flush, z_out_valid, z_out_ready;
  logic [15:0] z_in_ctrl, z_in_data, z_out_ctrl, z_out_data;
  logic [1:0]  z_occupancy;
  int          tests = 0;
  int          fails = 0;
  typedef struct {
    logic        rst, iv, clr, fl, ordy;
    logic [15:0] ic, id;
    logic        e_irdy, e_ov;
    logic [15:0] e_oc, e_od;
    logic [1:0]  e_occ;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  pipe_stage #(.CTRL_W(16), .DATA_W(16), .SKID(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .clr(clr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
  );
  pipe_stage #(.CTRL_W(16), .DATA_W(16), .SKID(0)) dut0 (
    .clk(clk), .rst(z_rst), .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl),
    .in_data(z_in_data), .clr(z_clr), .flush(z_flush), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_ctrl(z_out_ctrl), .out_data(z_out_data), .occupancy(z_occupancy)
  );
  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic iv, input logic [15:0] ic, input logic [15:0] id,
                     input logic c, input logic fl, input logic ordy, input logic e_irdy,
                     input logic e_ov, input logic [15:0] e_oc, input logic [15:0] e_od, input logic [1:0] e_occ);
    vec_t v;
    v = '{r, iv, c, fl, ordy, ic, id, e_irdy, e_ov, e_oc, e_od, e_occ};
    vecs.push_back(v);
  endtask
  initial begin
    rst = 1; in_valid = 0; in_ctrl = 0; in_data = 0; clr = 0; flush = 0; out_ready = 0;
    z_rst = 1; z_in_valid = 0; z_in_ctrl = 0; z_in_data = 0; z_clr = 0; z_flush = 0; z_out_ready = 0;
    add(1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 16'(k), 16'(16'h100 + k), 0, 0, 1, 1, 1, 16'(k), 16'(16'h100 + k), 1);
    add(0, 0, 16'h0, 16'h0, 0, 0, 1, 1, 0, 16'h8, 16'h108, 0);
    add(0, 1, 16'hA, 16'h10A, 0, 0, 0, 1, 1, 16'hA, 16'h10A, 1);
    add(0, 1, 16'hB, 16'h10B, 0, 0, 0, 1, 1, 16'hA, 16'h10A, 2);
    add(0, 1, 16'hC, 16'h10C, 0, 0, 0, 0, 1, 16'hA, 16'h10A, 2);
    add(0, 1, 16'hC, 16'h10C, 0, 0, 1, 0, 1, 16'hB, 16'h10B, 1);
    add(0, 1, 16'hC, 16'h10C, 0, 0, 1, 1, 1, 16'hC, 16'h10C, 1);
    add(0, 0, 16'h0, 16'h0, 0, 0, 1, 1, 0, 16'hC, 16'h10C, 0);
    add(0, 1, 16'hDEAD, 16'h1234, 1, 0, 0, 1, 1, 16'h0, 16'h1234, 1);
    add(0, 0, 16'h0, 16'h0, 0, 0, 1, 1, 0, 16'h0, 16'h1234, 0);
    add(0, 1, 16'h11, 16'h211, 0, 0, 0, 1, 1, 16'h11, 16'h211, 1);
    add(0, 1, 16'h22, 16'h222, 0, 0, 0, 1, 1, 16'h11, 16'h211, 2);
    add(0, 1, 16'h33, 16'h333, 0, 1, 1, 0, 0, 16'h0, 16'h211, 0);
    add(0, 1, 16'h44, 16'h444, 0, 0, 1, 1, 1, 16'h44, 16'h444, 1);
    add(0, 1, 16'h55, 16'h555, 0, 1, 0, 1, 0, 16'h0, 16'h444, 0);
    add(0, 1, 16'h66, 16'h666, 0, 0, 0, 1, 1, 16'h66, 16'h666, 1);
    add(0, 1, 16'h77, 16'h777, 0, 0, 0, 1, 1, 16'h66, 16'h666, 2);
    add(1, 1, 16'h88, 16'h888, 0, 0, 1, 0, 0, 16'h0, 16'h0, 0);
    add(0, 0, 16'h0, 16'h0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_ctrl = vecs[i].ic; in_data = vecs[i].id;
      clr = vecs[i].clr; flush = vecs[i].fl; out_ready = vecs[i].ordy;
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].e_irdy));
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
      chk("out_ctrl", i, 32'(out_ctrl), 32'(vecs[i].e_oc));
      chk("out_data", i, 32'(out_data), 32'(vecs[i].e_od));
      chk("occupancy", i, 32'(occupancy), 32'(vecs[i].e_occ));
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    z_rst = 1;
    #1;
    chk("s0_rst_in_ready", 0, 32'(z_in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("s0_rst_out_valid", 0, 32'(z_out_valid), 32'd0);
    @(negedge clk);
    z_rst = 0; z_in_valid = 1; z_in_ctrl = 16'h51; z_in_data = 16'h61; z_out_ready = 0;
    #1;
    chk("s0_in_ready_empty", 1, 32'(z_in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("s0_out_valid", 1, 32'(z_out_valid), 32'd1);
    chk("s0_out_ctrl", 1, 32'(z_out_ctrl), 32'h51);
    chk("s0_occupancy", 1, 32'(z_occupancy), 32'd1);
    @(negedge clk);
    z_in_ctrl = 16'h52; z_in_data = 16'h62; z_out_ready = 0;
    #1;
    chk("s0_in_ready_follow0", 2, 32'(z_in_ready), 32'd0);
    z_out_ready = 1;
    #1;
    chk("s0_in_ready_follow1", 2, 32'(z_in_ready), 32'd1);
    z_out_ready = 0;
    #1;
    chk("s0_in_ready_follow0b", 2, 32'(z_in_ready), 32'd0);
    z_out_ready = 1;
    @(posedge clk);
    #1;
    chk("s0_out_ctrl_b2b", 2, 32'(z_out_ctrl), 32'h52);
    chk("s0_out_data_b2b", 2, 32'(z_out_data), 32'h62);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      z_in_ctrl = 16'(16'h70 + k); z_in_data = 16'(16'h80 + k);
      @(posedge clk);
      #1;
      chk("s0_stream_valid", 3 + k, 32'(z_out_valid), 32'd1);
      chk("s0_stream_ctrl", 3 + k, 32'(z_out_ctrl), 32'(16'h70 + k));
      chk("s0_stream_occ", 3 + k, 32'(z_occupancy), 32'd1);
    end
    @(negedge clk);
    z_in_valid = 0;
    @(posedge clk);
    #1;
    chk("s0_drain_valid", 7, 32'(z_out_valid), 32'd0);
    chk("s0_drain_ctrl_hold", 7, 32'(z_out_ctrl), 32'h73);
    chk("s0_drain_occ", 7, 32'(z_occupancy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register, the successor to the fixed IF/ID/EX/MEM/WB latch: one instance sits between each pair of CPU pipeline stages. It carries a control bundle (instruction word and decoded signals) and a data bundle (PC, operands, ALU result, etc.) under a valid/ready handshake. It has an optional two-entry skid buffer so that stalls do not need a combinational ready path. Bubble insertion (`clr`) and full-stage flush (`flush`) are kept as separate controls.

## Interface
Parameters:
- `CTRL_W`, default 64: width of the control bundle; these bits are zeroed on bubble or flush.
- `DATA_W`, default 384: width of the data bundle; it is passed through and never zeroed except by reset.
- `SKID`, default 1: selects the buffer mode.
  - 1: two-entry skid buffer with fully registered `in_ready`.
  - 0: single register, and `in_ready` depends combinationally on `out_ready`.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: upstream stage offers a word.
- `in_ready` out 1: stage can accept a word this cycle.
- `in_ctrl` in CTRL_W: incoming control bundle.
- `in_data` in DATA_W: incoming data bundle.
- `clr` in 1: bubble. The word accepted this cycle is stored with ctrl forced to 0. It is ignored when no accept occurs.
- `flush` in 1: discard all stored entries and any same-cycle accept.
- `out_valid` out 1: stage holds a word for downstream.
- `out_ready` in 1: downstream consumes the word this cycle.
- `out_ctrl` out CTRL_W: head-entry control bundle.
- `out_data` out DATA_W: head-entry data bundle.
- `occupancy` out 2: number of stored entries, 0..2 (at most 1 when SKID=0).

## Operation
- Accept: `in_valid && in_ready`. Consume: `out_valid && out_ready`.
- Storage:
  - `main` is the head entry and drives `out_*`.
  - `skid` is the second entry and exists only when SKID=1.
- States when SKID=1:
  - **EMPTY**, occupancy 0:
    - accept → BUSY, `main` ← input.
  - **BUSY**, occupancy 1:
    - accept & consume → BUSY, `main` ← input.
    - accept & !consume → FULL, `skid` ← input.
    - consume & !accept → EMPTY.
    - neither → hold.
  - **FULL**, occupancy 2:
    - `in_ready`=0.
    - consume → BUSY, `main` ← `skid`.
- SKID=0:
  - `in_ready` = `!out_valid || out_ready`.
  - accept → `main` ← input, `out_valid` ← 1.
  - consume without accept → `out_valid` ← 0.
- `in_ready` (SKID=1) = `!rst && state != FULL`. It is derived only from registered state.
- `clr`: on accept, the stored ctrl is all-zero and the stored data is `in_data`. The entry still counts as valid, so downstream sees a NOP.
- `flush`:
  - Next cycle: state EMPTY, `out_valid`=0, occupancy 0, and the ctrl fields of `main` and `skid` are zeroed.
  - Data registers keep their values.
  - A same-cycle accept is dropped, even though `in_ready` was high.
- Priority: `rst` > `flush` > normal operation. `clr` together with `flush` is irrelevant, since flush wins.
- Holding: while `out_valid`=0, `out_ctrl` and `out_data` hold their last value. `out_ctrl` is zero after reset or flush.
- Ordering: entries leave strictly in FIFO order. No entry is duplicated or lost, except by flush.

## Timing
- Reset values: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, state EMPTY. `in_ready`=0 while `rst` is high, and 1 on the first cycle after `rst` falls.
- Latency: a word accepted at edge N is visible on `out_*` with `out_valid`=1 after edge N; downstream can consume it at edge N+1.
- Throughput: one word per cycle when `out_ready` is held high, in both modes.
- Combinational paths:
  - SKID=1: none from inputs to outputs.
  - SKID=0: `out_ready` → `in_ready` only.
- Ready recovery (SKID=1): after FULL → BUSY, `in_ready` rises in the same cycle as the state change, i.e. it is high for the cycle following the consuming edge.
- Reset mid-operation: all stored entries are discarded and the outputs go to their reset values at the next edge, regardless of the handshakes in flight.
- Flush while FULL with consume in the same cycle: the result is EMPTY and nothing is transferred.

## Test plan
- Streaming: SKID=1, `out_ready`=1, 8 words with ctrl=1..8 on consecutive cycles → out ctrl 1..8 appear on consecutive cycles with 1-cycle latency; occupancy stays ≤1.
- Stall: SKID=1, `out_ready`=0, push A, B, C → A and B are accepted, `in_ready`=0 on the cycle C is offered, occupancy=2. Release `out_ready` → A then B are output, then C is accepted with no loss and no duplication.
- Bubble: accept ctrl=0xDEAD, data=0x1234 with `clr`=1 → out_valid=1, out_ctrl=0, out_data=0x1234.
- Flush: FULL with A, B, flush=1 and in_valid=1 carrying C → next cycle out_valid=0, occupancy=0, out_ctrl=0; C is never output.
- Reset: assert rst in FULL with out_ready=1 → next cycle all outputs are 0 and in_ready=0; one cycle after rst deasserts, in_ready=1.
- SKID=0: with out_valid=1, toggle out_ready → in_ready follows out_ready in the same cycle; back-to-back transfers sustain 1 word per cycle.
